// File: rtl/acc_exec_unit.sv
// acc_exec_unit: accumulator and execute sequencer wrapped around the ALU.
// Accepts one ALU command per handshake, drives the ALU for one EXEC cycle,
// captures the result into the accumulator and pulses done (with err for
// illegal opcodes 6/7).
// Optional build macro ACC_ZFLAG_EN adds a registered zero flag output z_flag.
module acc_exec_unit #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc_out,
  output logic             done,
  output logic             err
`ifdef ACC_ZFLAG_EN
  ,
  output logic             z_flag
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_PASS = 3'd1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             illegal_op;

  assign illegal_op = (op_q[2:1] == 2'b11);

`ifdef ACC_ZFLAG_EN
  logic z_q, z_d;
  assign z_flag = z_q;
`endif

  // Next-state and next-output decode for the IDLE -> EXEC -> DONE sequence
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    operand_d = operand_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef ACC_ZFLAG_EN
    z_d       = z_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          op_d      = cmd_op;
          operand_d = cmd_operand;
          ready_d   = 1'b0;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        ready_d = 1'b0;
        done_d  = 1'b1;
        if (illegal_op) begin
          err_d = 1'b1;
        end else begin
          acc_d = alu_result;
`ifdef ACC_ZFLAG_EN
          z_d   = (alu_result == '0);
`endif
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      op_q      <= '0;
      operand_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef ACC_ZFLAG_EN
      z_q       <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef ACC_ZFLAG_EN
      z_q       <= z_d;
`endif
    end
  end

  // ALU sees the latched command only during EXEC; otherwise a safe pass of 0
  always_comb begin
    alu_sel = OP_PASS;
    alu_b   = '0;
    if (state_q == S_EXEC) begin
      alu_sel = op_q;
      alu_b   = operand_q;
    end
  end

  assign alu_a     = acc_q;
  assign acc_out   = acc_q;
  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_acc_exec_unit.sv
// Directed self-checking bench for acc_exec_unit with a behavioural ALU.
// Build with +define+ACC_ZFLAG_EN to also check the zero flag.
module tb_acc_exec_unit;

  localparam int unsigned WIDTH = 12;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_operand;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] acc_out;
  logic             done;
  logic             err;
`ifdef ACC_ZFLAG_EN
  logic             z_flag;
`endif

  int unsigned n_checks;
  int unsigned n_fail;
  logic [WIDTH-1:0] exp_prev;

  acc_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .acc_out     (acc_out),
    .done        (done),
    .err         (err)
`ifdef ACC_ZFLAG_EN
    ,
    .z_flag      (z_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; illegal selects return a marker so a wrongful capture shows
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    prod = {{WIDTH{1'b0}}, alu_a} * {{WIDTH{1'b0}}, alu_b};
    case (alu_sel)
      3'd0:    alu_result = '0;
      3'd1:    alu_result = alu_b;
      3'd2:    alu_result = alu_a + alu_b;
      3'd3:    alu_result = alu_a - alu_b;
      3'd4:    alu_result = prod[WIDTH-1:0];
      3'd5:    alu_result = alu_a + 1'b1;
      default: alu_result = 12'h5A5;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_z(input string tag, input logic exp_z);
`ifdef ACC_ZFLAG_EN
    check(tag, {31'd0, z_flag}, {31'd0, exp_z});
`else
    if (exp_z === 1'bx) $display("note: %s", tag);
`endif
  endtask

  // One full command: accept, EXEC, DONE, back to IDLE, checked every cycle
  task automatic do_cmd(input logic [2:0] op, input logic [WIDTH-1:0] operand,
                        input logic [WIDTH-1:0] exp_acc, input logic exp_err,
                        input logic exp_z);
    check("ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = operand;
    @(negedge clk);
    // EXEC: scramble inputs to show the in-flight command is latched
    cmd_valid   = 1'b0;
    cmd_op      = 3'd2;
    cmd_operand = 12'hABC;
    check("ready_exec", {31'd0, cmd_ready}, 32'd0);
    check("done_exec", {31'd0, done}, 32'd0);
    check("sel_exec", {29'd0, alu_sel}, {29'd0, op});
    check("b_exec", {20'd0, alu_b}, {20'd0, operand});
    check("a_exec", {20'd0, alu_a}, {20'd0, exp_prev});
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("err_done", {31'd0, err}, {31'd0, exp_err});
    check("acc_done", {20'd0, acc_out}, {20'd0, exp_acc});
    check("ready_done", {31'd0, cmd_ready}, 32'd0);
    check("sel_done", {29'd0, alu_sel}, 32'd1);
    check_z("z_done", exp_z);
    @(negedge clk);
    check("ready_back", {31'd0, cmd_ready}, 32'd1);
    check("done_low", {31'd0, done}, 32'd0);
    check("err_low", {31'd0, err}, 32'd0);
    check("b_idle", {20'd0, alu_b}, 32'd0);
    exp_prev = exp_acc;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    exp_prev    = '0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 3'd0;
    cmd_operand = '0;
    repeat (2) @(negedge clk);
    check("rst_acc", {20'd0, acc_out}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_sel", {29'd0, alu_sel}, 32'd1);
    check("rst_b", {20'd0, alu_b}, 32'd0);
    check_z("rst_z", 1'b1);
    rst = 1'b0;
    @(negedge clk);

    do_cmd(3'd1, 12'h123, 12'h123, 1'b0, 1'b0);  // pass
    do_cmd(3'd2, 12'h011, 12'h134, 1'b0, 1'b0);  // add
    do_cmd(3'd3, 12'h135, 12'hFFF, 1'b0, 1'b0);  // sub wraps
    do_cmd(3'd5, 12'h000, 12'h000, 1'b0, 1'b1);  // inc wraps to 0
    do_cmd(3'd1, 12'h040, 12'h040, 1'b0, 1'b0);  // pass
    do_cmd(3'd4, 12'h040, 12'h000, 1'b0, 1'b1);  // mul 0x1000 truncated
    do_cmd(3'd1, 12'h0A5, 12'h0A5, 1'b0, 1'b0);
    do_cmd(3'd0, 12'h777, 12'h000, 1'b0, 1'b1);  // clr
    do_cmd(3'd1, 12'h0A5, 12'h0A5, 1'b0, 1'b0);
    do_cmd(3'd6, 12'h001, 12'h0A5, 1'b1, 1'b0);  // illegal: acc, z unchanged
    do_cmd(3'd7, 12'h002, 12'h0A5, 1'b1, 1'b0);  // illegal

    // Busy: second valid pulse during EXEC must be ignored
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_operand = 12'h111;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_operand = 12'h222;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_done", {31'd0, done}, 32'd1);
    check("busy_acc", {20'd0, acc_out}, 32'h111);
    @(negedge clk);
    @(negedge clk);
    check("busy_noextra", {31'd0, done}, 32'd0);
    check("busy_acc2", {20'd0, acc_out}, 32'h111);
    check("busy_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset while in EXEC
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_operand = 12'h3C3;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_acc", {20'd0, acc_out}, 32'd0);
    check("mrst_ready", {31'd0, cmd_ready}, 32'd1);
    check("mrst_err", {31'd0, err}, 32'd0);
    check("mrst_sel", {29'd0, alu_sel}, 32'd1);
    check_z("mrst_z", 1'b1);
    @(negedge clk);
    check("mrst_done2", {31'd0, done}, 32'd0);
    check("mrst_acc2", {20'd0, acc_out}, 32'd0);
    exp_prev = '0;

    // Normal operation resumes after the mid-operation reset
    do_cmd(3'd2, 12'h00F, 12'h00F, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
